// File: rtl/pipe_adder_pkg.sv
// Shared definitions for the pipelined adder: operation modes and default sizing.
package pipe_adder_pkg;

  typedef enum logic [1:0] {
    ADD     = 2'b00,
    SUB     = 2'b01,
    SAT_ADD = 2'b10,
    ACC     = 2'b11
  } mode_e;

  localparam int DEFAULT_WIDTH  = 16;
  localparam int DEFAULT_STAGES = 2;

endpackage

// File: rtl/pipe_adder_stage.sv
// One valid/ready register slice; loads when empty or when its contents leave this edge.
module pipe_adder_stage #(
  parameter int DW = 17
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data
);

  logic          valid_q;
  logic [DW-1:0] data_q;

  assign in_ready  = !valid_q || out_ready;
  assign out_valid = valid_q;
  assign out_data  = data_q;

  // NOTE: sequential state uses non-blocking assignments so every slice samples
  // its neighbour's pre-edge value; blocking here would let data race down the chain.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      valid_q <= 1'b0;
      // NOTE: the payload is cleared too so a freshly reset pipe shows a zero result.
      data_q  <= '0;
    end else if (in_ready) begin
      valid_q <= in_valid;
      if (in_valid) data_q <= in_data;
    end
  end

endmodule

// File: rtl/pipe_adder.sv
// Pipelined add/sub/saturating-add/accumulate unit with valid/ready on both sides.
module pipe_adder
  import pipe_adder_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int STAGES = DEFAULT_STAGES
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       in_mode,
  input  logic             in_acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_carry
);

  mode_e            mode;
  logic             accept;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] acc_base;
  logic [WIDTH:0]   add_ext;
  logic [WIDTH:0]   sub_ext;
  logic [WIDTH:0]   acc_ext;
  logic [WIDTH:0]   result;

  logic             stg_valid [STAGES+1];
  logic             stg_ready [STAGES+1];
  logic [WIDTH:0]   stg_data  [STAGES+1];

  assign mode   = mode_e'(in_mode);
  assign accept = in_valid && in_ready;

  // Bit WIDTH of each extended result is the carry, borrow or overflow flag.
  assign acc_base = in_acc_clr ? '0 : acc_q;
  assign add_ext  = {1'b0, in_a} + {1'b0, in_b};
  assign sub_ext  = {1'b0, in_a} - {1'b0, in_b};
  assign acc_ext  = {1'b0, acc_base} + {1'b0, in_a};

  // NOTE: result gets a default before the case so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    result = add_ext;
    case (mode)
      ADD:     result = add_ext;
      SUB:     result = sub_ext;
      SAT_ADD: result = add_ext[WIDTH] ? {1'b1, {WIDTH{1'b1}}} : add_ext;
      ACC:     result = acc_ext;
      default: result = add_ext;
    endcase
  end

  // The accumulator moves only when an ACC transaction is actually taken.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      acc_q <= '0;
    end else if (accept && mode == ACC) begin
      acc_q <= acc_ext[WIDTH-1:0];
    end
  end

  assign stg_valid[0]      = in_valid;
  assign stg_data[0]       = result;
  assign stg_ready[STAGES] = out_ready;

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    pipe_adder_stage #(
      .DW (WIDTH + 1)
    ) u_stage (
      .clk       (clk),
      .rstn      (rstn),
      .in_valid  (stg_valid[i]),
      .in_ready  (stg_ready[i]),
      .in_data   (stg_data[i]),
      .out_valid (stg_valid[i+1]),
      .out_ready (stg_ready[i+1]),
      .out_data  (stg_data[i+1])
    );
  end

  // Gating with rstn keeps both handshakes quiet for the whole reset interval.
  assign in_ready               = rstn && stg_ready[0];
  assign out_valid              = rstn && stg_valid[STAGES];
  assign {out_carry, out_sum}   = stg_data[STAGES];

endmodule
